// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state type for the ALU command path.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_MOD = 4'b1011;
  localparam logic [3:0] OP_POW = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_e;

  // Opcodes whose b operand is a divisor and must be guarded against zero.
  function automatic logic is_div_op(input logic [3:0] sel);
    return (sel == OP_DIV) || (sel == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// In-order command FIFO; a push while full is dropped, pointers wrap modulo DEPTH.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Next storage, pointer and occupancy values from the qualified push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset flushes contents and overrides any same-edge push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time to an external combinational
// ALU, and holds each result until the consumer takes it.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_sel,
  input  logic [W-1:0]           cmd_a,
  input  logic [W-1:0]           cmd_b,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic [3:0]             alu_sel,
  output logic                   alu_en,
  input  logic [W-1:0]           alu_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_data,
  output logic [3:0]             res_sel,
  output logic                   res_err,
  output logic [$clog2(DEPTH):0] count
);

  import alu_pkg::*;

  localparam int CW = 4 + 2*W;

  seq_state_e     state_q, state_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic [3:0]     res_sel_q, res_sel_d;
  logic           res_err_q, res_err_d;

  logic [CW-1:0]  head_data;
  logic [3:0]     head_sel;
  logic [W-1:0]   head_a, head_b;
  logic           fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic           div_zero;

  // Ready depends only on occupancy, never on a pop happening in the same cycle.
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  assign head_sel = head_data[CW-1 -: 4];
  assign head_a   = head_data[2*W-1 -: W];
  assign head_b   = head_data[W-1:0];
  assign div_zero = is_div_op(head_sel) && (head_b == '0);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CW)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({cmd_sel, cmd_a, cmd_b}),
    .pop       (fifo_pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign res_data = res_data_q;
  assign res_sel  = res_sel_q;
  assign res_err  = res_err_q;

  // Sequencer next-state, ALU drive and result capture; ISSUE lasts exactly one cycle.
  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_sel_d  = res_sel_q;
    res_err_d  = res_err_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_sel    = '0;
    alu_en     = 1'b0;
    res_valid  = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        alu_a      = head_a;
        alu_b      = head_b;
        alu_sel    = head_sel;
        alu_en     = !div_zero;
        res_data_d = div_zero ? '0 : alu_result;
        res_sel_d  = head_sel;
        res_err_d  = div_zero;
        fifo_pop   = 1'b1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = (!fifo_empty || fifo_push) ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      res_data_q <= '0;
      res_sel_q  <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_sel_q  <= res_sel_d;
      res_err_q  <= res_err_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU and result scoreboard.
module tb_alu_cmd_sequencer;

  import alu_pkg::*;

  localparam int W     = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]   sel;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  logic                   clk;
  logic                   rst;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [3:0]             cmd_sel;
  logic [W-1:0]           cmd_a, cmd_b;
  logic [W-1:0]           alu_a, alu_b;
  logic [3:0]             alu_sel;
  logic                   alu_en;
  logic [W-1:0]           alu_result;
  logic                   res_valid;
  logic                   res_ready;
  logic [W-1:0]           res_data;
  logic [3:0]             res_sel;
  logic                   res_err;
  logic [$clog2(DEPTH):0] count;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   alu_en_cycles = 0;
  int   results_seen  = 0;
  exp_t sb_q[$];

  alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_sel    (cmd_sel),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_en     (alu_en),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_sel    (res_sel),
    .res_err    (res_err),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; a zero divisor yields all ones so the sequencer must mask it.
  function automatic logic [W-1:0] alu_model(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (sel)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_MUL: r = a * b;
      OP_DIV: r = (b == '0) ? '1 : a / b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: r = a << b[1:0];
      OP_SHR: r = a >> b[1:0];
      OP_MOD: r = (b == '0) ? '1 : a % b;
      OP_POW: begin
        r = W'(1);
        for (int i = 0; i < int'(b); i++) r = r * a;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic exp_t expect_of(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.sel = sel;
    if (((sel == OP_DIV) || (sel == OP_MOD)) && (b == '0)) begin
      e.data = '0;
      e.err  = 1'b1;
    end else begin
      e.data = alu_model(sel, a, b);
      e.err  = 1'b0;
    end
    return e;
  endfunction

  always_comb alu_result = alu_model(alu_sel, alu_a, alu_b);

  // Result monitor: every accepted result is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    if (alu_en) alu_en_cycles++;
    if (!rst && res_valid && res_ready) begin
      results_seen++;
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_result got sel=%b data=%0d err=%0d, expected none", res_sel, res_data, res_err);
      end else begin
        e = sb_q.pop_front();
        if ({res_sel, res_data, res_err} !== {e.sel, e.data, e.err}) begin
          tests_failed++;
          $display("[TB] FAIL result got sel=%b data=%0d err=%0d, expected sel=%b data=%0d err=%0d",
                   res_sel, res_data, res_err, e.sel, e.data, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b, output bit accepted);
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_a     = a;
    cmd_b     = b;
    @(negedge clk);
    accepted = cmd_ready;
    if (accepted) sb_q.push_back(expect_of(sel, a, b));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    tick();
    tick();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain_%s pending=%0d, expected 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if ({res_valid, res_data, res_sel, res_err} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result got valid=%0d data=%0d sel=%b err=%0d, expected all 0", res_valid, res_data, res_sel, res_err);
    end
    tests_run++;
    if ({alu_a, alu_b, alu_sel, alu_en} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_alu got a=%0d b=%0d sel=%b en=%0d, expected all 0", alu_a, alu_b, alu_sel, alu_en);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (count !== '0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_fifo got count=%0d ready=%0d, expected count=0 ready=1", count, cmd_ready);
    end
    tick();
  endtask

  task automatic test_single_op();
    int  en0;
    bit  acc;
    res_ready = 1'b1;
    en0 = alu_en_cycles;
    push_cmd(OP_ADD, 4'd3, 4'd4, acc);
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_accept got %0d, expected 1", acc);
    end
    @(negedge clk);
    tests_run++;
    if (res_valid !== 1'b0 || alu_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_after_e0 got valid=%0d en=%0d, expected 0 0", res_valid, alu_en);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if ({alu_en, alu_a, alu_b, alu_sel, res_valid} !== {1'b1, 4'd3, 4'd4, OP_ADD, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL single_issue got en=%0d a=%0d b=%0d sel=%b valid=%0d, expected 1 3 4 0000 0",
               alu_en, alu_a, alu_b, alu_sel, res_valid);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if ({res_valid, res_data, alu_en} !== {1'b1, 4'd7, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL single_hold got valid=%0d data=%0d en=%0d, expected 1 7 0", res_valid, res_data, alu_en);
    end
    tick();
    wait_drain("single");
    tests_run++;
    if (alu_en_cycles - en0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL single_en_cycles got %0d, expected 1", alu_en_cycles - en0);
    end
  endtask

  task automatic test_div_zero();
    int en0;
    bit acc;
    res_ready = 1'b1;
    en0 = alu_en_cycles;
    push_cmd(OP_DIV, 4'd9, 4'd0, acc);
    wait_drain("div_zero");
    tests_run++;
    if (alu_en_cycles != en0) begin
      tests_failed++;
      $display("[TB] FAIL div_zero_en got %0d cycles, expected 0", alu_en_cycles - en0);
    end
    en0 = alu_en_cycles;
    push_cmd(OP_DIV, 4'd9, 4'd2, acc);
    wait_drain("div_nonzero");
    tests_run++;
    if (alu_en_cycles - en0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL div_nonzero_en got %0d cycles, expected 1", alu_en_cycles - en0);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]   ops [5] = '{OP_ADD, OP_SUB, OP_MUL, OP_XOR, OP_MOD};
    logic [W-1:0] as  [5] = '{4'd1, 4'd5, 4'd3, 4'd10, 4'd13};
    logic [W-1:0] bs  [5] = '{4'd2, 4'd7, 4'd3, 4'd6, 4'd5};
    int r0, n_acc;
    bit acc;
    res_ready = 1'b0;
    r0 = results_seen;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(ops[i], as[i], bs[i], acc);
      if (acc) n_acc++;
    end
    tests_run++;
    if (n_acc != 5) begin
      tests_failed++;
      $display("[TB] FAIL full_accepts got %0d, expected 5", n_acc);
    end
    @(negedge clk);
    tests_run++;
    if ({count, cmd_ready, res_valid} !== {3'd4, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL full_state got count=%0d ready=%0d valid=%0d, expected 4 0 1", count, cmd_ready, res_valid);
    end
    tick();
    push_cmd(OP_OR, 4'd15, 4'd1, acc);
    tests_run++;
    if (acc !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_sixth_push got accepted=%0d, expected 0", acc);
    end
    @(negedge clk);
    tests_run++;
    if (count !== 3'd4) begin
      tests_failed++;
      $display("[TB] FAIL full_count_after_drop got %0d, expected 4", count);
    end
    tick();
    res_ready = 1'b1;
    wait_drain("full");
    tests_run++;
    if (results_seen - r0 != 5) begin
      tests_failed++;
      $display("[TB] FAIL full_result_count got %0d, expected 5", results_seen - r0);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    res_ready = 1'b1;
    push_cmd(OP_AND, 4'd12, 4'd10, acc);
    push_cmd(OP_SHL, 4'd3, 4'd2, acc);
    wait_drain("b2b_pre");
    res_ready = 1'b0;
    push_cmd(OP_SHR, 4'd12, 4'd2, acc);
    push_cmd(OP_POW, 4'd2, 4'd3, acc);
    push_cmd(OP_SUB, 4'd1, 4'd3, acc);
    @(negedge clk);
    tests_run++;
    if (count !== 3'd2 || res_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL simul_push_pop got count=%0d valid=%0d, expected 2 1", count, res_valid);
    end
    tick();
    res_ready = 1'b1;
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid_hold();
    bit acc;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(OP_ADD, W'(i), 4'd1, acc);
    @(negedge clk);
    tests_run++;
    if (count !== 3'd3 || res_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset got count=%0d valid=%0d, expected 3 1", count, res_valid);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    tests_run++;
    if ({res_valid, count, cmd_ready, alu_en, res_data, res_err} !== {1'b0, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset got valid=%0d count=%0d ready=%0d en=%0d data=%0d err=%0d, expected 0 0 1 0 0 0",
               res_valid, count, cmd_ready, alu_en, res_data, res_err);
    end
    tick();
    res_ready = 1'b1;
    push_cmd(OP_SUB, 4'd2, 4'd5, acc);
    wait_drain("post_reset");
  endtask

  task automatic test_random();
    logic [3:0] ops [11] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,
                             OP_XOR, OP_SHL, OP_SHR, OP_MOD, OP_POW};
    int  sent, cyc, r0;
    bit  have;
    sent = 0;
    cyc  = 0;
    have = 1'b0;
    r0   = results_seen;
    while (sent < 40 && cyc < 3000) begin
      res_ready = 1'($urandom_range(0, 1));
      if (!have) begin
        cmd_sel = ops[$urandom_range(0, 10)];
        cmd_a   = W'($urandom_range(0, 15));
        cmd_b   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(0, 15));
        have    = 1'b1;
      end
      cmd_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        sb_q.push_back(expect_of(cmd_sel, cmd_a, cmd_b));
        sent++;
        have = 1'b0;
      end
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain("random");
    tests_run++;
    if (sent != 40 || results_seen - r0 != 40) begin
      tests_failed++;
      $display("[TB] FAIL random_counts got sent=%0d results=%0d, expected 40 40", sent, results_seen - r0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_sel   = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b0;
    test_reset();
    test_single_op();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
